// File: rtl/result_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : result_buffer_pkg
// Purpose  : Shared definitions for the multi-channel result buffer:
//            register offsets, STATUS bit positions, fixed read codes,
//            the per-channel status record and its 32-bit packing.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package result_buffer_pkg;

  // Register offsets within a channel window (address[1:0])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_TOTAL  = 2'd3;

  // STATUS read-back layout
  localparam int STAT_EMPTY_BIT  = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_STICKY_BIT = 2;
  localparam int STAT_IRQEN_BIT  = 3;
  localparam int STAT_OVF_LSB    = 16;

  // STATUS write layout
  localparam int WR_FLUSH_BIT   = 0;
  localparam int WR_CLR_OVF_BIT = 1;
  localparam int WR_IRQEN_BIT   = 3;

  // Fixed read codes
  localparam logic [31:0] EMPTY_CODE      = 32'h0000_00FF;
  localparam logic [31:0] BAD_CH_CODE     = 32'hDEAD_0000;
  localparam logic [31:0] DATA_VALID_FLAG = 32'h8000_0000;

  typedef struct packed {
    logic [15:0] ovf_cnt;
    logic        irq_en;
    logic        ovf_sticky;
    logic        full;
    logic        empty;
  } ch_status_t;

  function automatic logic [31:0] pack_status(input ch_status_t s);
    logic [31:0] w;
    w                        = '0;
    w[STAT_OVF_LSB +: 16]    = s.ovf_cnt;
    w[STAT_IRQEN_BIT]        = s.irq_en;
    w[STAT_STICKY_BIT]       = s.ovf_sticky;
    w[STAT_FULL_BIT]         = s.full;
    w[STAT_EMPTY_BIT]        = s.empty;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_fifo_ch.sv
`default_nettype none
// ============================================================================
// Module   : result_fifo_ch
// Purpose  : One result channel: synchronous-RAM FIFO with a show-ahead
//            head, exact occupancy count, accepted-push total and
//            saturating overflow accounting.
// Ports    : clk, rst_n              clock / async active-low reset
//            push_i, push_data_i     raw result strobe and word
//            pop_i                   remove head (ignored when empty)
//            flush_i                 clear pointers, count, total
//            clr_ovf_i               clear overflow counter and sticky
//            head_o                  current head word (show-ahead)
//            count_o, total_o        occupancy / accepted pushes
//            status_o                packed ch_status_t (irq_en reads 0)
// Revision : 1.0 - initial release
// ============================================================================
module result_fifo_ch
  import result_buffer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16384,
  parameter int SKIP_ZERO = 1,
  localparam int AW       = $clog2(DEPTH),
  localparam int CNT_W    = AW + 1,
  localparam int ST_W     = $bits(ch_status_t)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic              clr_ovf_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [31:0]       total_o,
  output logic [ST_W-1:0]   status_o
);

  localparam logic [AW-1:0]    PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ram_q, byp_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       total_q, total_d;
  logic [15:0]       ovf_cnt_q, ovf_cnt_d;
  logic              sticky_q, sticky_d;
  logic              empty_q, full_q, stale_q, stale_d;
  logic              push_req, pop_ok, accept, drop;
  ch_status_t        st;

  assign push_req = push_i && ((SKIP_ZERO == 0) || (push_data_i != '0));
  assign pop_ok   = pop_i && !empty_q;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign accept   = push_req && !flush_i && (!full_q || pop_ok);
  assign drop     = push_req && !flush_i && full_q && !pop_ok;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    total_d   = total_q;
    ovf_cnt_d = ovf_cnt_q;
    sticky_d  = sticky_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      total_d  = '0;
    end else begin
      if (accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        total_d  = total_q + 32'd1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (accept && !pop_ok)      count_d = count_q + CNT_ONE;
      else if (!accept && pop_ok) count_d = count_q - CNT_ONE;
    end
    if (clr_ovf_i) begin
      ovf_cnt_d = '0;
      sticky_d  = 1'b0;
    end else if (drop) begin
      sticky_d = 1'b1;
      if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  // The RAM read port is addressed with the next read pointer, so ram_q
  // always holds the word at rd_ptr_q. When that same address is written
  // at the same edge the RAM returns the old contents; the prefetch
  // register byp_q supplies the freshly written word instead.
  assign stale_d = accept && (wr_ptr_q == rd_ptr_d);

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= push_data_i;
    ram_q <= mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      total_q   <= '0;
      ovf_cnt_q <= '0;
      sticky_q  <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      stale_q   <= 1'b0;
      byp_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      total_q   <= total_d;
      ovf_cnt_q <= ovf_cnt_d;
      sticky_q  <= sticky_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == CNT_MAX);
      stale_q   <= stale_d;
      byp_q     <= push_data_i;
    end
  end

  assign head_o  = stale_q ? byp_q : ram_q;
  assign count_o = count_q;
  assign total_o = total_q;

  always_comb begin
    st            = '0;
    st.ovf_cnt    = ovf_cnt_q;
    st.ovf_sticky = sticky_q;
    st.full       = full_q;
    st.empty      = empty_q;
  end
  assign status_o = st;

endmodule
`default_nettype wire

// File: rtl/result_buffer_mc.sv
`default_nettype none
// ============================================================================
// Module   : result_buffer_mc
// Purpose  : NUM_CH independent result FIFOs drained through an Avalon-MM
//            slave with read latency 1. Owns address decode, the
//            registered readdata mux, per-channel irq enables and irq.
// Ports    : clk, rst_n              clock / async active-low reset
//            in_valid, in_data       per-channel result strobe / words
//            chipselect, read, write, address, writedata   Avalon slave
//            readdata                registered read data
//            ch_empty, ch_full       per-channel flags
//            irq                     any enabled non-empty channel
// Revision : 1.0 - initial release
// ============================================================================
module result_buffer_mc
  import result_buffer_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16384,
  parameter int SKIP_ZERO = 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     chipselect,
  input  logic                     read,
  input  logic                     write,
  input  logic [CH_W+1:0]          address,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NUM_CH-1:0]        ch_empty,
  output logic [NUM_CH-1:0]        ch_full,
  output logic                     irq
);

  logic [NUM_CH-1:0][DATA_W-1:0] head;
  logic [NUM_CH-1:0][CNT_W-1:0]  count;
  logic [NUM_CH-1:0][31:0]       total;
  ch_status_t [NUM_CH-1:0]       ch_st;
  logic [NUM_CH-1:0]             pop, flush, clr_ovf;
  logic [NUM_CH-1:0]             irq_en_q, irq_en_d;
  logic [31:0]                   readdata_q, readdata_d;

  logic              rd_en, wr_en, ch_ok;
  logic [CH_W-1:0]   sel_ch;
  logic [1:0]        sel_reg;
  logic [DATA_W-1:0] sel_head;
  logic [CNT_W-1:0]  sel_count;
  logic [31:0]       sel_total;
  ch_status_t        sel_st;
  logic              unused_wdata;

  assign rd_en   = chipselect && read;
  assign wr_en   = chipselect && write;
  assign sel_ch  = address[CH_W+1:2];
  assign sel_reg = address[1:0];
  assign ch_ok   = ({1'b0, sel_ch} < (CH_W+1)'(NUM_CH));
  assign unused_wdata = ^{writedata[31:4], writedata[2]};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    result_fifo_ch #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .SKIP_ZERO (SKIP_ZERO)
    ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (in_valid[k]),
      .push_data_i (in_data[k*DATA_W +: DATA_W]),
      .pop_i       (pop[k]),
      .flush_i     (flush[k]),
      .clr_ovf_i   (clr_ovf[k]),
      .head_o      (head[k]),
      .count_o     (count[k]),
      .total_o     (total[k]),
      .status_o    (ch_st[k])
    );
    assign ch_empty[k] = ch_st[k].empty;
    assign ch_full[k]  = ch_st[k].full;
  end

  always_comb begin
    pop        = '0;
    flush      = '0;
    clr_ovf    = '0;
    irq_en_d   = irq_en_q;
    readdata_d = readdata_q;
    sel_head   = '0;
    sel_count  = '0;
    sel_total  = '0;
    sel_st     = '0;
    // Only indices below NUM_CH can match, so an out-of-range channel
    // selects nothing and triggers no side effects.
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_ch == CH_W'(k)) begin
        sel_head      = head[k];
        sel_count     = count[k];
        sel_total     = total[k];
        sel_st        = ch_st[k];
        sel_st.irq_en = irq_en_q[k];
        if (rd_en && (sel_reg == REG_DATA) && !ch_st[k].empty) pop[k] = 1'b1;
        if (wr_en && (sel_reg == REG_STATUS)) begin
          flush[k]    = writedata[WR_FLUSH_BIT];
          clr_ovf[k]  = writedata[WR_CLR_OVF_BIT];
          irq_en_d[k] = writedata[WR_IRQEN_BIT];
        end
      end
    end
    if (rd_en) begin
      if (!ch_ok) begin
        readdata_d = BAD_CH_CODE;
      end else begin
        case (sel_reg)
          REG_DATA: begin
            if (sel_st.empty) begin
              readdata_d = EMPTY_CODE;
            end else begin
              readdata_d = DATA_VALID_FLAG;
              readdata_d[DATA_W-1:0] = sel_head;
            end
          end
          REG_COUNT:  readdata_d = 32'(sel_count);
          REG_STATUS: readdata_d = pack_status(sel_st);
          default:    readdata_d = sel_total;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata_q <= '0;
      irq_en_q   <= '0;
    end else begin
      readdata_q <= readdata_d;
      irq_en_q   <= irq_en_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(~ch_empty & irq_en_q);

endmodule
`default_nettype wire

// File: tb/tb_result_buffer_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_buffer_mc
// Purpose  : Self-checking bench for result_buffer_mc (NUM_CH=3, DATA_W=8,
//            DEPTH=4, SKIP_ZERO=1). A queue-based model predicts readdata,
//            flags and irq every cycle; directed steps pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_buffer_mc;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [23:0] in_data;
  logic        chipselect, read, write;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [2:0]  ch_empty, ch_full;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_buffer_mc #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .SKIP_ZERO (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .ch_empty   (ch_empty),
    .ch_full    (ch_full),
    .irq        (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mq [3][$];
  int unsigned m_total [3];
  int          m_ovf [3];
  bit          m_sticky [3];
  bit          m_irqen [3];
  logic [31:0] m_rd;
  bit          m_pop [3];
  bit          m_fl [3];
  bit          m_cl [3];
  int          m_ch;
  logic [1:0]  m_reg;
  logic [7:0]  m_w;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mq[k].delete();
        m_total[k]  = 0;
        m_ovf[k]    = 0;
        m_sticky[k] = 0;
        m_irqen[k]  = 0;
      end
      m_rd = 32'h0;
    end else begin
      m_ch  = int'(address[3:2]);
      m_reg = address[1:0];
      for (int k = 0; k < 3; k++) begin
        m_pop[k] = 0;
        m_fl[k]  = 0;
        m_cl[k]  = 0;
      end
      if (chipselect && read) begin
        if (m_ch >= NUM_CH) m_rd = 32'hDEAD_0000;
        else begin
          case (m_reg)
            2'd0: begin
              if (mq[m_ch].size() == 0) m_rd = 32'h0000_00FF;
              else begin
                m_rd = 32'h8000_0000 | 32'(mq[m_ch][0]);
                m_pop[m_ch] = 1;
              end
            end
            2'd1: m_rd = 32'(mq[m_ch].size());
            2'd2: m_rd = {16'(m_ovf[m_ch]), 12'd0, m_irqen[m_ch], m_sticky[m_ch],
                          mq[m_ch].size() == DEPTH, mq[m_ch].size() == 0};
            default: m_rd = m_total[m_ch];
          endcase
        end
      end
      if (chipselect && write && m_ch < NUM_CH && m_reg == 2'd2) begin
        m_fl[m_ch]    = writedata[0];
        m_cl[m_ch]    = writedata[1];
        m_irqen[m_ch] = writedata[3];
      end
      for (int k = 0; k < 3; k++) begin
        m_w = in_data[k*8 +: 8];
        if (m_fl[k]) begin
          mq[k].delete();
          m_total[k] = 0;
        end else begin
          if (m_pop[k]) void'(mq[k].pop_front());
          if (in_valid[k] && m_w != 8'h00) begin
            if (mq[k].size() < DEPTH) begin
              mq[k].push_back(m_w);
              m_total[k]++;
            end else begin
              if (m_ovf[k] < 65535) m_ovf[k]++;
              m_sticky[k] = 1;
            end
          end
        end
        if (m_cl[k]) begin
          m_ovf[k]    = 0;
          m_sticky[k] = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [2:0] c_empty, c_full;
  logic       c_irq;

  always @(negedge clk) begin
    if (rst_n) begin
      c_irq = 1'b0;
      for (int k = 0; k < 3; k++) begin
        c_empty[k] = (mq[k].size() == 0);
        c_full[k]  = (mq[k].size() == DEPTH);
        if (mq[k].size() != 0 && m_irqen[k]) c_irq = 1'b1;
      end
      chk("model_readdata", readdata, m_rd);
      chk("model_ch_empty", 32'(ch_empty), 32'(c_empty));
      chk("model_ch_full", 32'(ch_full), 32'(c_full));
      chk("model_irq", 32'(irq), 32'(c_irq));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [2:0] v, input logic [23:0] d, input logic cs,
                      input logic rd, input logic wr, input logic [3:0] a,
                      input logic [31:0] wd);
    in_valid   = v;
    in_data    = d;
    chipselect = cs;
    read       = rd;
    write      = wr;
    address    = a;
    writedata  = wd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(3'b000, 24'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic rd_reg(input int ch, input int r);
    step(3'b000, 24'h0, 1'b1, 1'b1, 1'b0, 4'(ch * 4 + r), 32'h0);
  endtask

  task automatic wr_status(input int ch, input logic [31:0] wd);
    step(3'b000, 24'h0, 1'b1, 1'b0, 1'b1, 4'(ch * 4 + 2), wd);
  endtask

  task automatic push1(input int k, input logic [7:0] d);
    step(3'(1 << k), 24'(d) << (8 * k), 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = '0; in_data = '0; chipselect = 0; read = 0; write = 0;
    address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_ch_empty", 32'(ch_empty), 32'h7);
    chk("reset_ch_full", 32'(ch_full), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    idle(1);

    for (int c = 0; c < 3; c++) begin
      rd_reg(c, 1);
      chk("count_after_reset", readdata, 32'h0);
    end
    rd_reg(0, 0);
    chk("data_empty_ch0", readdata, 32'h0000_00FF);
    chk("empty_flags_idle", 32'(ch_empty), 32'h7);

    // zero word is skipped; back-to-back DATA reads
    push1(1, 8'h05); push1(1, 8'h00); push1(1, 8'h07);
    idle(2);
    rd_reg(1, 0); chk("ch1_pop0", readdata, 32'h8000_0005);
    rd_reg(1, 0); chk("ch1_pop1", readdata, 32'h8000_0007);
    rd_reg(1, 0); chk("ch1_pop_empty", readdata, 32'h0000_00FF);
    rd_reg(1, 3); chk("ch1_total", readdata, 32'h2);

    // overflow on ch2
    for (int i = 1; i <= 6; i++) push1(2, 8'(i));
    idle(1);
    chk("ch2_full_flag", 32'(ch_full[2]), 32'h1);
    rd_reg(2, 1); chk("ch2_count_full", readdata, 32'h4);
    rd_reg(2, 2); chk("ch2_status_ovf", readdata, 32'h0002_0006);
    wr_status(2, 32'h2);
    rd_reg(2, 2); chk("ch2_status_cleared", readdata, 32'h0000_0002);
    for (int i = 1; i <= 4; i++) begin
      rd_reg(2, 0); chk("ch2_drain", readdata, 32'h8000_0000 | 32'(i));
    end
    rd_reg(2, 0); chk("ch2_drained_empty", readdata, 32'h0000_00FF);

    // push into full ch0 concurrent with a pop
    for (int i = 0; i < 4; i++) push1(0, 8'(8'h11 + i));
    idle(2);
    step(3'b001, 24'h000015, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0);
    chk("ch0_full_pushpop", readdata, 32'h8000_0011);
    rd_reg(0, 1); chk("ch0_count_kept", readdata, 32'h4);
    rd_reg(0, 2); chk("ch0_status_no_ovf", readdata, 32'h0000_0002);
    rd_reg(0, 0); chk("ch0_pop_next", readdata, 32'h8000_0012);

    // flush with concurrent push (ch0 holds 3 words)
    step(3'b001, 24'h000020, 1'b1, 1'b0, 1'b1, 4'h2, 32'h1);
    rd_reg(0, 1); chk("ch0_count_flushed", readdata, 32'h0);
    rd_reg(0, 3); chk("ch0_total_flushed", readdata, 32'h0);
    rd_reg(0, 0); chk("ch0_data_flushed", readdata, 32'h0000_00FF);
    chk("ch0_empty_flushed", 32'(ch_empty[0]), 32'h1);

    // irq on ch1
    wr_status(1, 32'h8);
    chk("irq_idle", 32'(irq), 32'h0);
    push1(1, 8'h33);
    idle(1);
    chk("irq_set", 32'(irq), 32'h1);
    rd_reg(1, 0); chk("ch1_irq_pop", readdata, 32'h8000_0033);
    chk("irq_cleared", 32'(irq), 32'h0);

    // channel field out of range
    rd_reg(3, 0); chk("bad_ch_data", readdata, 32'hDEAD_0000);
    rd_reg(3, 1); chk("bad_ch_count", readdata, 32'hDEAD_0000);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
